// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider request sequencer: FSM state encoding,
// default core latency and the operand patterns that bypass the core.
package div_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // The radix-2 core is built for 32-bit operands only.
  localparam int CORE_DATA_WIDTH  = 32;
  localparam int DEF_CORE_LATENCY = 34;

  localparam logic [CORE_DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CORE_DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(CORE_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous request FIFO. Pointers carry one extra wrap bit so that full and
// empty can be told apart when the index bits are equal.
module div_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is dropped; a pop from an empty one is ignored.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Request front-end for the iterative divider core: queues tagged requests,
// resolves divide-by-zero and signed overflow locally, runs the rest on the core.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH   = CORE_DATA_WIDTH,
  parameter int TAG_WIDTH    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CORE_LATENCY = DEF_CORE_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic                  req_signed,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_quot,
  output logic [DATA_WIDTH-1:0] rsp_rem,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_dbz,
  output logic [DATA_WIDTH-1:0] core_in1,
  output logic [DATA_WIDTH-1:0] core_in2,
  output logic                  core_sign,
  output logic                  core_start,
  input  logic [DATA_WIDTH-1:0] core_div,
  input  logic [DATA_WIDTH-1:0] core_rem,
  output logic [2:0]            dbg_state
);

  // Handshakes: a request transfers on a clock edge where req_valid && req_ready,
  // a response on an edge where rsp_valid && rsp_ready; a valid side holds its
  // payload stable until the transfer happens.

  localparam int ENTRY_W = 2*DATA_WIDTH + 1 + TAG_WIDTH;
  localparam int CNT_W   = $clog2(CORE_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LATENCY - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] in1_q, in1_d;
  logic [DATA_WIDTH-1:0] in2_q, in2_d;
  logic                  sign_q, sign_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;
  logic                  head_signed;
  logic [TAG_WIDTH-1:0]  head_tag;
  logic                  head_dbz;
  logic                  head_ovf;

  assign fifo_wdata = {req_a, req_b, req_signed, req_tag};
  assign {head_a, head_b, head_signed, head_tag} = fifo_rdata;

  div_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_dbz = (head_b == '0);
  assign head_ovf = head_signed && (head_a == INT_MIN) && (head_b == ALL_ONES);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    sign_d   = sign_q;
    tag_d    = tag_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    fifo_pop = 1'b0;
    case (state_q)
      // The core has no reset of its own, so wait out any computation that
      // was running when this block was reset.
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          in1_d    = head_a;
          in2_d    = head_b;
          sign_d   = head_signed;
          tag_d    = head_tag;
          if (head_dbz) begin
            quot_d  = ALL_ONES;
            rem_d   = head_a;
            dbz_d   = 1'b1;
            state_d = ST_RESP;
          end else if (head_ovf) begin
            quot_d  = head_a;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        cnt_d   = CNT_LOAD;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          quot_d  = core_div;
          rem_d   = core_rem;
          dbz_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_DRAIN;
        cnt_d   = CNT_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DRAIN;
      cnt_q   <= CNT_LOAD;
      in1_q   <= '0;
      in2_q   <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sign_q  <= sign_d;
      tag_q   <= tag_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign req_ready  = !fifo_full;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_quot   = quot_q;
  assign rsp_rem    = rem_q;
  assign rsp_tag    = tag_q;
  assign rsp_dbz    = dbz_q;
  assign core_in1   = in1_q;
  assign core_in2   = in2_q;
  assign core_sign  = sign_q;
  assign core_start = (state_q == ST_LAUNCH);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural fixed-latency divider
// core and a response scoreboard.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int LAT = 34;
  localparam int EW  = TW + 1 + 2*DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic          req_signed;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_quot;
  logic [DW-1:0] rsp_rem;
  logic [TW-1:0] rsp_tag;
  logic          rsp_dbz;
  logic [DW-1:0] core_in1;
  logic [DW-1:0] core_in2;
  logic          core_sign;
  logic          core_start;
  logic [DW-1:0] core_div;
  logic [DW-1:0] core_rem;
  logic [2:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_cyc = 0;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_quot   (rsp_quot),
    .rsp_rem    (rsp_rem),
    .rsp_tag    (rsp_tag),
    .rsp_dbz    (rsp_dbz),
    .core_in1   (core_in1),
    .core_in2   (core_in2),
    .core_sign  (core_sign),
    .core_start (core_start),
    .core_div   (core_div),
    .core_rem   (core_rem),
    .dbg_state  (dbg_state)
  );

  // Core model: results valid from LAT cycles after the start cycle, junk before.
  logic [DW-1:0] m_div = '0;
  logic [DW-1:0] m_rem = '0;
  int            m_cnt = 0;
  logic          m_have = 1'b0;

  always @(posedge clk) begin
    if (core_start) begin
      if (core_sign) begin
        m_div <= $signed(core_in1) / $signed(core_in2);
        m_rem <= $signed(core_in1) % $signed(core_in2);
      end else begin
        m_div <= core_in1 / core_in2;
        m_rem <= core_in1 % core_in2;
      end
      m_cnt  <= LAT - 1;
      m_have <= 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign core_div = (m_have && m_cnt == 0) ? m_div : 32'hDEAD_BEEF;
  assign core_rem = (m_have && m_cnt == 0) ? m_rem : 32'hBAAD_F00D;

  // Start-pulse and operand-stability monitor.
  logic          prev_start = 1'b0;
  int            start_cnt = 0;
  int            dbl_start = 0;
  int            stable_viol = 0;
  int            win = 0;
  int            last_start_cyc = 0;
  logic [DW-1:0] snap1 = '0;
  logic [DW-1:0] snap2 = '0;
  logic          snaps = 1'b0;

  always @(posedge clk) begin
    prev_start <= core_start;
    if (core_start && prev_start) dbl_start <= dbl_start + 1;
    if (core_start) begin
      start_cnt      <= start_cnt + 1;
      last_start_cyc <= cyc;
      win            <= LAT;
      snap1          <= core_in1;
      snap2          <= core_in2;
      snaps          <= core_sign;
    end else if (win > 0) begin
      win <= win - 1;
      if (core_in1 !== snap1 || core_in2 !== snap2 || core_sign !== snaps)
        stable_viol <= stable_viol + 1;
    end
  end

  // driver / scoreboard tasks
  task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [TW-1:0] tag, input logic dbz,
                            input logic [DW-1:0] q, input logic [DW-1:0] r);
    exp_q.push_back({tag, dbz, q, r});
  endtask

  task automatic cmp_rsp(input string name, input logic [EW-1:0] e);
    chk({name, "_quot"}, rsp_quot, e[2*DW-1:DW]);
    chk({name, "_rem"}, rsp_rem, e[DW-1:0]);
    chk({name, "_dbz"}, {31'b0, rsp_dbz}, {31'b0, e[2*DW]});
    chk({name, "_tag"}, {28'b0, rsp_tag}, {28'b0, e[EW-1 -: TW]});
  endtask

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic push_req(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic s, input logic [TW-1:0] tag);
    int n;
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    req_signed = s;
    req_tag    = tag;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'b0, req_ready}, 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    logic [EW-1:0] e;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rsp_cyc = cyc;
    n_vec++;
    assert (rsp_valid === 1'b1 && exp_q.size() > 0) else begin
      n_err++;
      $error("FAIL %s_present observed valid=%b queued=%0d expected valid=1 queued>0",
             name, rsp_valid, exp_q.size());
    end
    if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp_rsp(name, e);
    end
    if (rsp_ready) @(negedge clk);
  endtask

  int r_cyc;
  int base;
  int sv_base;
  int db_base;
  int n;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_signed = 1'b0;
    req_tag    = '0;
    rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_core_start", {31'b0, core_start}, 32'd0);
    chk("rst_core_sign", {31'b0, core_sign}, 32'd0);
    chk("rst_rsp_dbz", {31'b0, rsp_dbz}, 32'd0);
    chk("rst_rsp_quot", rsp_quot, 32'd0);
    chk("rst_rsp_rem", rsp_rem, 32'd0);
    chk("rst_rsp_tag", {28'b0, rsp_tag}, 32'd0);
    chk("rst_core_in1", core_in1, 32'd0);
    chk("rst_core_in2", core_in2, 32'd0);
    chk("rst_state", {29'b0, dbg_state}, 32'(ST_DRAIN));

    // 100/7 unsigned issued during the drain
    rst   = 1'b0;
    r_cyc = cyc;
    base  = start_cnt;
    expect_rsp(4'd3, 1'b0, 32'd14, 32'd2);
    push_req(32'd100, 32'd7, 1'b0, 4'd3);
    while (cyc < r_cyc + 34) @(negedge clk);
    chk("drain_no_start", start_cnt - base, 32'd0);
    chk("drain_done_idle", {29'b0, dbg_state}, 32'(ST_IDLE));
    wait_rsp("udiv");
    chk("first_start_cyc", last_start_cyc - r_cyc, 32'd35);

    // signed -100/7 on the normal path
    base    = start_cnt;
    sv_base = stable_viol;
    db_base = dbl_start;
    expect_rsp(4'd4, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    push_req(32'hFFFF_FF9C, 32'd7, 1'b1, 4'd4);
    wait_rsp("sdiv");
    chk("sdiv_latency", rsp_cyc - acc_cyc, 32'd37);
    chk("sdiv_starts", start_cnt - base, 32'd1);
    chk("sdiv_pulse_1cyc", dbl_start - db_base, 32'd0);
    chk("sdiv_operands_stable", stable_viol - sv_base, 32'd0);

    // divide by zero bypass
    base = start_cnt;
    expect_rsp(4'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234);
    push_req(32'h0000_1234, 32'd0, 1'b0, 4'd5);
    wait_rsp("dbz");
    chk("dbz_latency", rsp_cyc - acc_cyc, 32'd2);
    chk("dbz_no_start", start_cnt - base, 32'd0);

    // signed overflow bypass
    base = start_cnt;
    expect_rsp(4'd6, 1'b0, 32'h8000_0000, 32'd0);
    push_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd6);
    wait_rsp("ovf");
    chk("ovf_latency", rsp_cyc - acc_cyc, 32'd2);
    chk("ovf_no_start", start_cnt - base, 32'd0);

    // same operands unsigned are an ordinary divide
    base = start_cnt;
    expect_rsp(4'd7, 1'b0, 32'd0, 32'h8000_0000);
    push_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'd7);
    wait_rsp("uovf");
    chk("uovf_latency", rsp_cyc - acc_cyc, 32'd37);
    chk("uovf_starts", start_cnt - base, 32'd1);

    // backpressure: one in flight plus four queued fills the FIFO
    rsp_ready = 1'b0;
    base = start_cnt;
    expect_rsp(4'd1, 1'b0, 32'd100, 32'd0);
    expect_rsp(4'd2, 1'b0, 32'd0, 32'd7);
    expect_rsp(4'd3, 1'b1, 32'hFFFF_FFFF, 32'd5);
    expect_rsp(4'd4, 1'b0, 32'hFFFF_FFF2, 32'd2);
    expect_rsp(4'd5, 1'b0, 32'h7FFF_FFFF, 32'd1);
    push_req(32'd1000, 32'd10, 1'b0, 4'd1);
    push_req(32'd7, 32'd9, 1'b0, 4'd2);
    push_req(32'd5, 32'd0, 1'b0, 4'd3);
    push_req(32'd100, 32'hFFFF_FFF9, 1'b1, 4'd4);
    push_req(32'hFFFF_FFFF, 32'd2, 1'b0, 4'd5);
    chk("full_ready_low", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_a     = 32'd77;
    req_b     = 32'd7;
    req_tag   = 4'd6;
    repeat (3) @(negedge clk);
    chk("full_ready_held_low", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() > 0) cmp_rsp("stall_hold", exp_q[0]);
      chk("stall_valid_held", {31'b0, rsp_valid}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_rsp("burst");
    repeat (60) @(negedge clk);
    chk("burst_starts", start_cnt - base, 32'd4);
    chk("burst_no_extra_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("burst_queue_empty", exp_q.size(), 32'd0);

    // reset in WAIT drops the computation and the queued request
    push_req(32'd50, 32'd5, 1'b0, 4'd8);
    repeat (10) @(negedge clk);
    chk("mid_state_wait", {29'b0, dbg_state}, 32'(ST_WAIT));
    push_req(32'd2, 32'd1, 1'b0, 4'd9);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", {29'b0, dbg_state}, 32'(ST_DRAIN));
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_tag", {28'b0, rsp_tag}, 32'd0);
    rst   = 1'b0;
    r_cyc = cyc;
    base  = start_cnt;
    expect_rsp(4'd10, 1'b0, 32'd3, 32'd0);
    push_req(32'd9, 32'd3, 1'b0, 4'd10);
    wait_rsp("post_rst");
    chk("post_rst_start_cyc", last_start_cyc - r_cyc, 32'd35);
    chk("post_rst_starts", start_cnt - base, 32'd1);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
